// File: rtl/md5_read_stream.sv
`timescale 1ns/1ps
// md5_read_stream: credit-controlled AXI4 line reader feeding 512-bit MD5 blocks; MD5_STREAM_PERF_EN adds busy/stall counters
module md5_read_stream #(
  parameter int APP_ID = 0,
  parameter int MAX_BURST = 64,
  parameter int FIFO_DEPTH = 128
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [63:0]  base_addr,
  input  logic [31:0]  num_lines,
  output logic [15:0]  arid,
  output logic [63:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic         arvalid,
  input  logic         arready,
  input  logic [15:0]  rid,
  input  logic [511:0] rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic [511:0] blk_data,
  output logic         blk_last,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [31:0]  lines_out,
  output logic [31:0]  busy_cycles,
  output logic [31:0]  stall_cycles
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state;
  logic [57:0] line_addr, src_line;
  logic [31:0] remaining, src_rem, total, push_cnt, room, len_a, len;
  logic [CW-1:0] reserved, credits, count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [512:0] mem [FIFO_DEPTH];
  logic push, pop, load, accept, unused;
  assign unused = ^{rid, rlast, base_addr[5:0]};
  assign accept = state == IDLE && start;
  assign busy = state != IDLE;
  assign rready = busy;
  assign push = rvalid && rready;
  assign blk_valid = count != '0;
  assign pop = blk_valid && blk_ready;
  assign blk_data = blk_valid ? mem[rd_ptr][511:0] : '0;
  assign blk_last = blk_valid && mem[rd_ptr][512];
  assign arid = arvalid ? 16'(APP_ID) : '0;
  assign arsize = arvalid ? 3'd6 : 3'd0;
  assign credits = CW'(FIFO_DEPTH) - reserved;
  // Next burst: min of burst cap, lines left and lines to the 4 KB boundary; gated by free credits
  always_comb begin
    src_line = state == IDLE ? base_addr[63:6] : line_addr;
    src_rem = state == IDLE ? num_lines : remaining;
    room = 32'd64 - {26'd0, src_line[5:0]};
    len_a = src_rem < room ? src_rem : room;
    len = len_a > 32'(MAX_BURST) ? 32'(MAX_BURST) : len_a;
    load = (accept || (state == ISSUE && (!arvalid || arready))) && src_rem != 0 && 32'(credits) >= len;
  end
  // Job control, AR issue with credit reservation at load, status
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      arvalid <= 1'b0;
      araddr <= '0;
      arlen <= '0;
      line_addr <= '0;
      remaining <= '0;
      total <= '0;
      reserved <= '0;
      done <= 1'b0;
      err <= 1'b0;
      lines_out <= '0;
    end else begin
      if (load) begin
        araddr <= {src_line, 6'd0};
        arlen <= 8'(len - 32'd1);
        arvalid <= 1'b1;
        line_addr <= src_line + 58'(len);
        remaining <= src_rem - len;
      end else if (arready)
        arvalid <= 1'b0;
      reserved <= reserved + (load ? CW'(len) : '0) - (pop ? CW'(1) : '0);
      if (push && rresp != 2'd0)
        err <= 1'b1;
      if (state == IDLE) begin
        if (start) begin
          total <= num_lines;
          lines_out <= '0;
          done <= num_lines == 0;
          if (num_lines != 0)
            state <= ISSUE;
        end
      end else begin
        if (pop)
          lines_out <= lines_out + 32'd1;
        if (state == ISSUE && arvalid && arready && remaining == 0)
          state <= DRAIN;
        if (pop && blk_last) begin
          state <= IDLE;
          done <= 1'b1;
        end
      end
    end
  // Line FIFO pointers; each beat is tagged as last when it is line total-1
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      push_cnt <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + (push ? CW'(1) : '0) - (pop ? CW'(1) : '0);
      push_cnt <= accept ? '0 : push ? push_cnt + 32'd1 : push_cnt;
    end
  // FIFO storage, no reset needed since reads are gated by occupancy
  always_ff @(posedge clk)
    if (push)
      mem[wr_ptr] <= {push_cnt == total - 32'd1, rdata};
`ifdef MD5_STREAM_PERF_EN
  // Saturating busy and stall counters, cleared on accepted start
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      busy_cycles <= '0;
      stall_cycles <= '0;
    end else if (accept) begin
      busy_cycles <= '0;
      stall_cycles <= '0;
    end else begin
      if (busy && ~&busy_cycles)
        busy_cycles <= busy_cycles + 32'd1;
      if (blk_valid && !blk_ready && ~&stall_cycles)
        stall_cycles <= stall_cycles + 32'd1;
    end
`else
  assign busy_cycles = '0;
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_md5_read_stream.sv
`timescale 1ns/1ps
// tb_md5_read_stream: randomized AXI slave and block sink checked against a spec-level model of bursts and blocks
module tb_md5_read_stream;
  localparam int MB = 64;
  localparam int DEPTH = 128;
  logic clk = 0, rst = 1, start = 0;
  logic [63:0] base_addr = '0;
  logic [31:0] num_lines = '0;
  logic [15:0] arid;
  logic [63:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic arvalid, arready = 0;
  logic [15:0] rid = '0;
  logic [511:0] rdata = '0;
  logic [1:0] rresp = '0;
  logic rlast = 0, rvalid = 0, rready;
  logic [511:0] blk_data;
  logic blk_last, blk_valid, blk_ready = 0;
  logic busy, done, err;
  logic [31:0] lines_out, busy_cycles, stall_cycles;
  int tests = 0, fails = 0;

  md5_read_stream dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_lines(num_lines),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .blk_data(blk_data), .blk_last(blk_last), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .busy(busy), .done(done), .err(err), .lines_out(lines_out),
    .busy_cycles(busy_cycles), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [511:0] got, logic [511:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] line_data(logic [57:0] l);
    logic [511:0] d;
    for (int k = 0; k < 16; k++)
      d[k*32 +: 32] = (l[31:0] * 32'h9E3779B1) ^ l[57:26] ^ 32'(k * 7919);
    return d;
  endfunction

  typedef struct {logic [63:0] addr; logic [7:0] len;} ar_t;
  ar_t exp_ar[$];
  logic [57:0] exp_line[$];
  bit exp_last[$];
  logic [57:0] beat_line[$];
  bit beat_last[$];
  int err_beat = -1, beat_idx = 0, cyc = 0, ready_from = 0, ar_count = 0;
  int outstanding = 0, max_out = 0, hold_bad = 0, stall_bad = 0, busy_m = 0, stall_m = 0;
  bit err_exp = 0, last_popped = 0, prev_stall = 0, prev_last = 0, took = 0, mlast;
  logic [511:0] prev_data = '0;
  logic [57:0] mline;
  ar_t e;

  // Expected AR list and block order derived directly from the burst sizing rules
  task automatic plan(logic [63:0] base, int n);
    logic [57:0] a = base[63:6];
    int rem = n, idx = 0, len;
    exp_ar.delete();
    exp_line.delete();
    exp_last.delete();
    while (rem > 0) begin
      len = rem;
      if (64 - int'(a[5:0]) < len) len = 64 - int'(a[5:0]);
      if (MB < len) len = MB;
      exp_ar.push_back('{{a, 6'd0}, 8'(len - 1)});
      for (int i = 0; i < len; i++) begin
        exp_line.push_back(a + 58'(i));
        exp_last.push_back(idx == n - 1);
        idx++;
      end
      a += 58'(len);
      rem -= len;
    end
  endtask

  // Bus monitor at negedge, slave/sink drive shortly after posedge
  always begin
    @(negedge clk);
    took = 0;
    if (rst) begin
      beat_line.delete();
      beat_last.delete();
      exp_ar.delete();
      exp_line.delete();
      exp_last.delete();
      prev_stall = 0;
      last_popped = 0;
      outstanding = 0;
      busy_m = 0;
      stall_m = 0;
    end else begin
      if (last_popped) begin
        check("done_rise", 512'(done), 512'(1));
        check("busy_fall", 512'(busy), 512'(0));
        last_popped = 0;
      end
      if (busy) busy_m++;
      if (blk_valid && !blk_ready) stall_m++;
      if (prev_stall && !(blk_valid && blk_data == prev_data && blk_last == prev_last)) hold_bad++;
      prev_stall = blk_valid && !blk_ready;
      prev_data = blk_data;
      prev_last = blk_last;
      if (rvalid && !rready) stall_bad++;
      if (rvalid && rready) begin
        void'(beat_line.pop_front());
        void'(beat_last.pop_front());
        beat_idx++;
        took = 1;
      end
      if (arvalid && arready) begin
        ar_count++;
        if (exp_ar.size() == 0)
          check("ar_extra", 512'(araddr), 512'(0));
        else begin
          e = exp_ar.pop_front();
          check("araddr", 512'(araddr), 512'(e.addr));
          check("arlen", 512'(arlen), 512'(e.len));
        end
        check("arsize", 512'(arsize), 512'(6));
        check("arid", 512'(arid), 512'(0));
        for (int i = 0; i <= int'(arlen); i++) begin
          beat_line.push_back(araddr[63:6] + 58'(i));
          beat_last.push_back(i == int'(arlen));
        end
        outstanding += int'(arlen) + 1;
        if (outstanding > max_out) max_out = outstanding;
      end
      if (blk_valid && blk_ready) begin
        outstanding--;
        if (exp_line.size() == 0)
          check("blk_extra", blk_data, 512'(0));
        else begin
          mline = exp_line.pop_front();
          mlast = exp_last.pop_front();
          check("blk_data", blk_data, line_data(mline));
          check("blk_last", 512'(blk_last), 512'(mlast));
          if (mlast) last_popped = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    arready = $urandom_range(0, 2) != 0;
    blk_ready = cyc >= ready_from && $urandom_range(0, 3) != 0;
    if (rst) rvalid = 0;
    else if (!rvalid || took) begin
      rvalid = beat_line.size() != 0 && $urandom_range(0, 3) != 0;
      if (rvalid) begin
        rdata = line_data(beat_line[0]);
        rlast = beat_last[0];
        rresp = beat_idx == err_beat ? 2'd2 : 2'd0;
      end
    end
  end

  task automatic pulse_start(logic [63:0] base, int n);
    @(posedge clk);
    #2;
    start = 1;
    base_addr = base;
    num_lines = n;
    @(posedge clk);
    #2;
    start = 0;
  endtask

  task automatic run_job(string tag, logic [63:0] base, int n, int eb, int hold, int restart_at);
    plan(base, n);
    err_beat = eb;
    beat_idx = 0;
    ar_count = 0;
    max_out = 0;
    hold_bad = 0;
    stall_bad = 0;
    if (eb >= 0 && eb < n) err_exp = 1;
    @(posedge clk);
    #2;
    start = 1;
    base_addr = base;
    num_lines = n;
    ready_from = cyc + hold;
    @(posedge clk);
    #2;
    start = 0;
    busy_m = 0;
    stall_m = 0;
    for (int i = 0; i < 30000 && !done; i++) begin
      if (i == restart_at) begin
        check({tag, "_restart_busy"}, 512'(busy), 512'(1));
        pulse_start(base + 64'h10000, 7);
      end
      @(negedge clk);
    end
    if (!done) check({tag, "_timeout"}, 512'(done), 512'(1));
    @(negedge clk);
    check({tag, "_ar_left"}, 512'(exp_ar.size()), 512'(0));
    check({tag, "_blk_left"}, 512'(exp_line.size()), 512'(0));
    check({tag, "_lines_out"}, 512'(lines_out), 512'(n));
    check({tag, "_done"}, 512'(done), 512'(1));
    check({tag, "_busy"}, 512'(busy), 512'(0));
    check({tag, "_err"}, 512'(err), 512'(err_exp));
    check({tag, "_hold"}, 512'(hold_bad), 512'(0));
    check({tag, "_rstall"}, 512'(stall_bad), 512'(0));
    check({tag, "_credit"}, 512'(max_out <= DEPTH), 512'(1));
`ifdef MD5_STREAM_PERF_EN
    check({tag, "_busy_cyc"}, 512'(busy_cycles), 512'(busy_m));
    check({tag, "_stall_cyc"}, 512'(stall_cycles), 512'(stall_m));
`else
    check({tag, "_busy_cyc"}, 512'(busy_cycles), 512'(0));
    check({tag, "_stall_cyc"}, 512'(stall_cycles), 512'(0));
`endif
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    rst = 0;
    @(negedge clk);
    check("rst_arvalid", 512'(arvalid), 512'(0));
    check("rst_blk_valid", 512'(blk_valid), 512'(0));
    check("rst_busy", 512'(busy), 512'(0));
    check("rst_done", 512'(done), 512'(0));
    check("rst_lines_out", 512'(lines_out), 512'(0));
    check("rst_rready", 512'(rready), 512'(0));

    run_job("single", 64'h1000, 1, -1, 0, -1);
    check("single_ars", 512'(ar_count), 512'(1));

    run_job("split", 64'h1F80, 4, -1, 3, -1);
    check("split_ars", 512'(ar_count), 512'(2));

    run_job("zero", 64'h5000, 0, -1, 0, -1);
    check("zero_ars", 512'(ar_count), 512'(0));

    run_job("restart", 64'h2340, 100, -1, 0, 20);

    run_job("backpressure", 64'h40000, 512, -1, 1010, -1);
`ifdef MD5_STREAM_PERF_EN
    check("bp_stall_1000", 512'(stall_cycles >= 1000), 512'(1));
`endif

    for (int j = 0; j < 6; j++)
      run_job("random", {$urandom, $urandom}, $urandom_range(1, 300), -1, $urandom_range(0, 60), -1);

    run_job("error", 64'h8000, 8, 3, 0, -1);

    plan(64'h30000, 64);
    err_beat = -1;
    beat_idx = 0;
    pulse_start(64'h30000, 64);
    for (int i = 0; i < 5000 && lines_out < 5; i++) @(negedge clk);
    check("mid_busy", 512'(busy), 512'(1));
    @(posedge clk);
    #2;
    rst = 1;
    err_exp = 0;
    #1;
    check("mid_rst_outs", 512'({arvalid, araddr, arlen, arsize, arid, rready, blk_valid, blk_last, busy, done, err}), 512'(0));
    check("mid_rst_data", blk_data, 512'(0));
    check("mid_rst_cnt", 512'({lines_out, busy_cycles, stall_cycles}), 512'(0));
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
    run_job("post_rst", 64'hABC0, 37, -1, 5, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
